fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the 8-bit fifo between NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
// Contents: arbiter state enum, default data width, clog2 helper.
// Purely declarative; no ports, no timing, no flow control.
package fifo_arb_pkg;

  localparam int ARB_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: round-robin selector, first set req bit after last_owner (wrapping).
// Latency: purely combinational.
// Backpressure: none; owner_vld low when no request is set.
// Ports: req (request vector), last_owner (previous owner index),
//        owner (selected index), owner_vld (any request present).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      last_owner,
  output logic [OW-1:0]      owner,
  output logic               owner_vld
);

  always_comb begin
    int idx;
    owner     = '0;
    owner_vld = 1'b0;
    idx       = 0;
    // Scan last_owner+1 .. last_owner+NUM_REQ, so the previous owner has
    // the lowest priority and only wins if nobody else is asking.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_owner) + i) % NUM_REQ;
      if (!owner_vld && req[idx]) begin
        owner_vld = 1'b1;
        owner     = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one fifo write port among NUM_REQ producers, round-robin, burst-bounded.
// Latency: one IDLE arbitration cycle per grant, then one word per cycle combinationally acked.
// Backpressure: fifo_full_flag stalls the owner (no write, no ack, burst count held).
// Ports: clk, reset (sync, active-high); req/data from producers; ack/grant back to them;
//        fifo_write_en/fifo_data_in to the fifo; fifo_full_flag from the fifo;
//        wr_count per-requester accepted-word counters, only when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full_flag
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  wr_count
`endif
);

  localparam int OW = clog2(NUM_REQ);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [OW-1:0] OWNER_INIT = OW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);

  arb_state_t          state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_owner_q, last_owner_d;
  logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;

  logic [OW-1:0]       pick_owner;
  logic                pick_vld;
  logic                wr_en;
  logic                owner_req;
  logic [DATA_WIDTH-1:0] owner_dat;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OW      (OW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .owner      (pick_owner),
    .owner_vld  (pick_vld)
  );

  // Write path: combinational from the registered owner.
  always_comb begin
    owner_dat = '0;
    owner_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == OW'(k)) begin
        owner_dat = data[k*DATA_WIDTH +: DATA_WIDTH];
        owner_req = req[k];
      end
    end
    // reset gating keeps the fifo pins quiet during a mid-burst reset
    wr_en         = (state_q == ARB_BURST) && owner_req && !fifo_full_flag && !reset;
    fifo_write_en = wr_en;
    fifo_data_in  = wr_en ? owner_dat : '0;
    ack           = grant_q & {NUM_REQ{wr_en}};
  end

  assign grant = grant_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    grant_d      = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          owner_d     = pick_owner;
          grant_d     = ONE << pick_owner;
          burst_cnt_d = '0;
          state_d     = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // A stalled cycle (full) leaves burst_cnt untouched.
        if (wr_en) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (!owner_req || (wr_en && burst_cnt_q == BURST_LAST)) begin
          state_d      = ARB_IDLE;
          last_owner_d = owner_q;
          grant_d      = '0;
          burst_cnt_d  = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= OWNER_INIT;
      burst_cnt_q  <= '0;
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      grant_q      <= grant_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] wr_count_q, wr_count_d;

  // Saturating counters: stick at all ones instead of wrapping.
  always_comb begin
    wr_count_d = wr_count_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ack[k] && (wr_count_q[k] != {CNT_WIDTH{1'b1}})) begin
        wr_count_d[k] = wr_count_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter with a behavioural 8-deep fifo and simple producers.
// Producer k offers base[k]+n while n < lim[k], advancing n on ack[k].
// Optional FIFO_ARB_STATS_EN section exercises the saturating word counters.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] data;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   grant;
  logic            fifo_write_en;
  logic [DW-1:0]   fifo_data_in;
  logic            fifo_full_flag;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] wr_count;
  logic [NR-1:0]    ack4;
  logic [NR-1:0]    grant4;
  logic             we4;
  logic [DW-1:0]    din4;
  logic [NR*4-1:0]  wr_count4;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .data           (data),
    .ack            (ack),
    .grant          (grant),
    .fifo_write_en  (fifo_write_en),
    .fifo_data_in   (fifo_data_in),
    .fifo_full_flag (fifo_full_flag)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_count       (wr_count)
`endif
  );

`ifdef FIFO_ARB_STATS_EN
  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4), .CNT_WIDTH(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .data           (data),
    .ack            (ack4),
    .grant          (grant4),
    .fifo_write_en  (we4),
    .fifo_data_in   (din4),
    .fifo_full_flag (fifo_full_flag),
    .wr_count       (wr_count4)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-deep fifo.
  logic [DW-1:0] mem [8];
  int  f_wp, f_rp, f_cnt;
  logic rd_en;
  logic f_rd;
  assign f_rd = rd_en && (f_cnt > 0);
  assign fifo_full_flag = (f_cnt == 8);

  always @(posedge clk) begin
    if (reset) begin
      f_wp  <= 0;
      f_rp  <= 0;
      f_cnt <= 0;
    end else begin
      if (fifo_write_en) begin
        mem[f_wp] <= fifo_data_in;
        f_wp      <= (f_wp + 1) % 8;
      end
      if (f_rd) f_rp <= (f_rp + 1) % 8;
      f_cnt <= f_cnt + (fifo_write_en ? 1 : 0) - (f_rd ? 1 : 0);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int n_ovf = 0;
  int nidx [NR];
  int lim  [NR];
  logic [DW-1:0] base [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_prod();
    for (int k = 0; k < NR; k++) begin
      req[k] = (nidx[k] < lim[k]);
      data[k*DW +: DW] = base[k] + DW'(nidx[k]);
    end
  endtask

  // Called at negedge+1: capture this cycle's ack, advance through the edge,
  // then present the producers' next words.
  task automatic cycle();
    logic [NR-1:0] a;
    a = ack;
    if (fifo_write_en && fifo_full_flag) n_ovf++;
    @(negedge clk);
    for (int k = 0; k < NR; k++) if (a[k]) nidx[k]++;
    drive_prod();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_en = 1'b0;
    for (int k = 0; k < NR; k++) begin
      nidx[k] = 0;
      lim[k]  = 0;
      base[k] = '0;
    end
    drive_prod();
    cycle();
    cycle();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rd_en = 1'b0;
    req   = '0;
    data  = '0;

    // ---- reset state ----
    do_reset();
    reset = 1'b1;
    lim[0] = 4;
    drive_prod();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_we", fifo_write_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_din", fifo_data_in, 0);

    // ---- 1) single requester, bubble every 4 words, readback ----
    do_reset();
    lim[0] = 8;
    drive_prod();
    #1;
    for (int c = 0; c < 11; c++) begin
      chk("t1_we", fifo_write_en, (c % 5 != 0) ? 1 : 0);
      if (c % 5 != 0) begin
        chk("t1_din", fifo_data_in, (c / 5) * 4 + (c % 5) - 1);
        chk("t1_ack", ack, 4'b0001);
      end else begin
        chk("t1_grant_idle", grant, 0);
      end
      cycle();
    end
    chk("t1_full", fifo_full_flag, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_rdback", mem[f_rp], i);
      rd_en = 1'b1;
      cycle();
    end
    rd_en = 1'b0;
    chk("t1_empty", f_cnt, 0);

    // ---- 2) all four requesters, round-robin 0,1,2,3,0 ----
    do_reset();
    rd_en = 1'b1;
    for (int k = 0; k < NR; k++) begin
      lim[k]  = 8;
      base[k] = DW'(k * 16);
    end
    drive_prod();
    #1;
    for (int c = 0; c < 25; c++) begin
      chk("t2_we", fifo_write_en, (c % 5 != 0) ? 1 : 0);
      if (c % 5 != 0) begin
        chk("t2_grant", grant, 1 << ((c / 5) % 4));
        chk("t2_din", fifo_data_in, ((c / 5) % 4) * 16 + ((c / 5) >= 4 ? 4 : 0) + (c % 5) - 1);
      end else begin
        chk("t2_grant_idle", grant, 0);
      end
      cycle();
    end

    // ---- 3) fill fifo, stall while full, resume one word per freed slot ----
    do_reset();
    lim[0] = 20;
    drive_prod();
    #1;
    for (int c = 0; c < 10; c++) cycle();
    chk("t3_full", fifo_full_flag, 1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_ack", ack, 0);
      chk("t3_stall_we", fifo_write_en, 0);
      chk("t3_stall_grant", grant, 4'b0001);
      if (i == 4) rd_en = 1'b1;
      cycle();
    end
    rd_en = 1'b0;
    chk("t3_resume_we", fifo_write_en, 1);
    chk("t3_resume_ack", ack, 4'b0001);
    chk("t3_resume_din", fifo_data_in, 8);
    cycle();
    chk("t3_one_write", fifo_write_en, 0);
    for (int j = 0; j < 3; j++) begin
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
      chk("t3_more_din", fifo_data_in, 9 + j);
      chk("t3_more_grant", grant, 4'b0001);
      cycle();
    end
    chk("t3_burst_end", grant, 0);

    // ---- 4) owner drops req after 2 words, req2 pending ----
    do_reset();
    rd_en = 1'b1;
    lim[0] = 2;
    lim[2] = 3;
    base[2] = 8'h20;
    drive_prod();
    #1;
    cycle();
    cycle();
    cycle();
    chk("t4_drop_we", fifo_write_en, 0);
    chk("t4_drop_grant", grant, 4'b0001);
    cycle();
    chk("t4_idle_grant", grant, 0);
    cycle();
    chk("t4_new_grant", grant, 4'b0100);
    chk("t4_new_din", fifo_data_in, 8'h20);

    // ---- 5) reset mid-burst after 2 words ----
    do_reset();
    rd_en = 1'b1;
    lim[0] = 8;
    lim[1] = 8;
    base[1] = 8'h10;
    drive_prod();
    #1;
    cycle();
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    chk("t5_rst_we", fifo_write_en, 0);
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_din", fifo_data_in, 0);
    cycle();
    reset = 1'b0;
    #1;
    chk("t5_after_grant", grant, 0);
    chk("t5_after_we", fifo_write_en, 0);
    cycle();
    chk("t5_regrant", grant, 4'b0001);
    chk("t5_regrant_din", fifo_data_in, 2);

`ifdef FIFO_ARB_STATS_EN
    // ---- 6) statistics counters ----
    do_reset();
    rd_en = 1'b1;
    lim[1] = 12;
    drive_prod();
    #1;
    for (int c = 0; c < 20; c++) cycle();
    chk("t6_cnt1", wr_count[16 +: 16], 12);
    chk("t6_cnt0", wr_count[0 +: 16], 0);
    chk("t6_cnt2", wr_count[32 +: 16], 0);
    chk("t6_cnt3", wr_count[48 +: 16], 0);
    chk("t6_cnt4b_12", wr_count4[4 +: 4], 12);
    lim[1] = 20;
    drive_prod();
    #1;
    for (int c = 0; c < 15; c++) cycle();
    chk("t6_cnt1_20", wr_count[16 +: 16], 20);
    chk("t6_cnt4b_sat", wr_count4[4 +: 4], 15);
`endif

    chk("no_overflow", n_ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
